// File: rtl/ftdi_pkg.sv
// ftdi_pkg: shared state encodings and widths for the FTDI receive frame loader.
package ftdi_pkg;
  typedef enum logic [1:0] {BUS_IDLE, BUS_OE, BUS_READ} bus_state_t;
  typedef enum logic [1:0] {P_SYNC, P_B0, P_B1, P_B2} parse_state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int PIX_W = 20;
endpackage

// File: rtl/ftdi_rx_frame_loader_if.sv
// ftdi_rx_frame_loader_if: FT232H pins, framebuffer write port and swap handshake.
interface ftdi_rx_frame_loader_if #(parameter int ADDR_W = 14);
  logic [7:0] data_in;
  logic rxf_n;
  logic txe_n;
  logic oe_n;
  logic rd_n;
  logic wr_n;
  logic [ftdi_pkg::PIX_W-1:0] fb_wdata;
  logic [ADDR_W-1:0] fb_waddr;
  logic fb_we;
  logic frame_start;
  logic fb_sel;
  logic frame_done;
  logic sync_err;
  modport master (
    output data_in, rxf_n, txe_n, frame_start,
    input oe_n, rd_n, wr_n, fb_wdata, fb_waddr, fb_we, fb_sel, frame_done, sync_err
  );
  modport slave (
    input data_in, rxf_n, txe_n, frame_start,
    output oe_n, rd_n, wr_n, fb_wdata, fb_waddr, fb_we, fb_sel, frame_done, sync_err
  );
endinterface

// File: rtl/ftdi_pixel_packer.sv
// ftdi_pixel_packer: parses sync + 3-byte pixels from an accepted-byte stream into
// framebuffer writes, with a mid-frame idle timeout that aborts back to sync hunt.
module ftdi_pixel_packer import ftdi_pkg::*; #(
  parameter int NUM_PIXELS = 16384,
  parameter int ADDR_W = 14,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int TIMEOUT_CYC = 600000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [7:0] rx_byte,
  input  logic rx_valid,
  output logic fb_we,
  output logic [PIX_W-1:0] fb_wdata,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic frame_done,
  output logic sync_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  parse_state_t state, state_nx;
  logic [15:0] lo;
  logic [ADDR_W-1:0] pix_cnt;
  logic [TW-1:0] idle_cnt;
  logic last, timeout, bad_sync;
  assign last = pix_cnt == ADDR_W'(NUM_PIXELS - 1);
  assign timeout = state != P_SYNC && !rx_valid && idle_cnt == TW'(TIMEOUT_CYC - 1);
  assign bad_sync = rx_valid && state == P_SYNC && rx_byte != SYNC_BYTE;
  always_comb begin
    state_nx = state;
    if (timeout) state_nx = P_SYNC;
    else if (rx_valid)
      case (state)
        P_SYNC: state_nx = rx_byte == SYNC_BYTE ? P_B0 : P_SYNC;
        P_B0: state_nx = P_B1;
        P_B1: state_nx = P_B2;
        default: state_nx = last ? P_SYNC : P_B0;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= P_SYNC;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lo <= '0;
      pix_cnt <= '0;
      idle_cnt <= '0;
      fb_we <= 1'b0;
      fb_wdata <= '0;
      fb_waddr <= '0;
      frame_done <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      fb_we <= rx_valid && state == P_B2;
      frame_done <= rx_valid && state == P_B2 && last;
      sync_err <= bad_sync || timeout;
      idle_cnt <= (state == P_SYNC || rx_valid || timeout) ? '0 : idle_cnt + 1'b1;
      if (timeout) pix_cnt <= '0;
      if (rx_valid)
        case (state)
          P_SYNC: if (rx_byte == SYNC_BYTE) pix_cnt <= '0;
          P_B0: lo[7:0] <= rx_byte;
          P_B1: lo[15:8] <= rx_byte;
          default: begin
            fb_wdata <= {rx_byte[3:0], lo};
            fb_waddr <= pix_cnt;
            pix_cnt <= last ? '0 : pix_cnt + 1'b1;
          end
        endcase
    end
endmodule

// File: rtl/ftdi_rx_frame_loader.sv
// ftdi_rx_frame_loader: FT232H 245-sync FIFO read sequencer feeding the pixel packer,
// plus the double-buffer swap that flips fb_sel on frame_start after a completed frame.
module ftdi_rx_frame_loader import ftdi_pkg::*; #(
  parameter int NUM_PIXELS = 16384,
  parameter int ADDR_W = 14,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int TIMEOUT_CYC = 600000
) (
  input logic clk_60,
  input logic rst_n,
  ftdi_rx_frame_loader_if.slave bus
);
  bus_state_t bstate, bstate_nx;
  logic accept, swap_pending, unused_txe;
  assign unused_txe = bus.txe_n;
  assign bus.wr_n = 1'b1;
  // rd_n follows rxf_n combinationally so the strobe drops the cycle the FIFO empties
  assign bus.rd_n = bstate == BUS_READ ? bus.rxf_n : 1'b1;
  assign accept = bstate == BUS_READ && !bus.rxf_n;
  always_comb begin
    bstate_nx = bstate;
    bstate_nx = bstate == BUS_IDLE ? (bus.rxf_n ? BUS_IDLE : BUS_OE) :
                bstate == BUS_OE ? BUS_READ : (bus.rxf_n ? BUS_IDLE : BUS_READ);
  end
  always_ff @(posedge clk_60 or negedge rst_n)
    if (!rst_n) begin
      bstate <= BUS_IDLE;
      bus.oe_n <= 1'b1;
    end else begin
      bstate <= bstate_nx;
      bus.oe_n <= bstate_nx == BUS_IDLE;
    end
  always_ff @(posedge clk_60 or negedge rst_n)
    if (!rst_n) begin
      swap_pending <= 1'b0;
      bus.fb_sel <= 1'b0;
    end else begin
      bus.fb_sel <= bus.fb_sel ^ (bus.frame_start & swap_pending);
      swap_pending <= swap_pending ? !bus.frame_start : bus.frame_done;
    end
  ftdi_pixel_packer #(
    .NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC_BYTE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_packer (
    .clk(clk_60),
    .rst_n(rst_n),
    .rx_byte(bus.data_in),
    .rx_valid(accept),
    .fb_we(bus.fb_we),
    .fb_wdata(bus.fb_wdata),
    .fb_waddr(bus.fb_waddr),
    .frame_done(bus.frame_done),
    .sync_err(bus.sync_err)
  );
endmodule

// File: tb/tb_ftdi_rx_frame_loader.sv
// tb_ftdi_rx_frame_loader: directed FIFO stimulus with a byte-level frame model checked every cycle.
module tb_ftdi_rx_frame_loader;
  localparam int NP = 4;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int fails = 0;
  ftdi_rx_frame_loader_if #(.ADDR_W(14)) bus();
  ftdi_rx_frame_loader #(.NUM_PIXELS(NP), .ADDR_W(14), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk_60(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: bus phase (0 idle, 1 output-enable, 2 reading) and frame parse progress.
  int phase = 0, pix = 0, idle = 0;
  bit in_frame = 0, pend = 0, acc;
  bit e_we = 0, e_done = 0, e_err = 0, e_sel = 0;
  logic [13:0] e_addr = '0;
  logic [19:0] e_data = '0;
  logic [7:0] pq[$];

  initial begin : model
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0; in_frame = 0; pix = 0; idle = 0; pend = 0; pq.delete();
        e_we = 0; e_done = 0; e_err = 0; e_sel = 0;
      end
      chk("oe_n", bus.oe_n, phase == 0);
      chk("rd_n", bus.rd_n, phase == 2 ? bus.rxf_n : 1'b1);
      chk("wr_n", bus.wr_n, 1);
      chk("fb_we", bus.fb_we, e_we);
      chk("frame_done", bus.frame_done, e_done);
      chk("sync_err", bus.sync_err, e_err);
      chk("fb_sel", bus.fb_sel, e_sel);
      if (e_we) begin
        chk("fb_waddr", bus.fb_waddr, e_addr);
        chk("fb_wdata", bus.fb_wdata, e_data);
      end
      if (rst_n) begin
        acc = phase == 2 && !bus.rxf_n;
        if (pend && bus.frame_start) begin e_sel = !e_sel; pend = 0; end
        else if (e_done) pend = 1;
        phase = phase == 0 ? (bus.rxf_n ? 0 : 1) : phase == 1 ? 2 : (bus.rxf_n ? 0 : 2);
        e_we = 0; e_done = 0; e_err = 0;
        if (acc) begin
          idle = 0;
          if (!in_frame) begin
            if (bus.data_in == 8'hA5) begin in_frame = 1; pix = 0; pq.delete(); end
            else e_err = 1;
          end else begin
            pq.push_back(bus.data_in);
            if (pq.size() == 3) begin
              e_we = 1;
              e_addr = 14'(pix);
              e_data = {pq[2][3:0], pq[1], pq[0]};
              pq.delete();
              if (pix == NP - 1) begin e_done = 1; in_frame = 0; end
              else pix++;
            end
          end
        end else if (in_frame) begin
          idle++;
          if (idle == TO) begin e_err = 1; in_frame = 0; idle = 0; pq.delete(); end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit ok = 0;
    bus.data_in = b;
    bus.rxf_n = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.rd_n;
    end
    chk("send_strobe", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_pix(input logic [19:0] p, input logic [3:0] junk);
    send(p[7:0]); send(p[15:8]); send({junk, p[19:16]});
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.rxf_n = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int errs, dones;
    bus.data_in = '0; bus.rxf_n = 1'b1; bus.txe_n = 1'b1; bus.frame_start = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_oe_n", bus.oe_n, 1); chk("rst_rd_n", bus.rd_n, 1); chk("rst_wr_n", bus.wr_n, 1);
    chk("rst_we", bus.fb_we, 0); chk("rst_wdata", bus.fb_wdata, 0); chk("rst_waddr", bus.fb_waddr, 0);
    chk("rst_sel", bus.fb_sel, 0); chk("rst_done", bus.frame_done, 0); chk("rst_err", bus.sync_err, 0);
    // first frame: oe_n leads rd_n by one cycle, then a full 4-pixel frame
    @(posedge clk); #1 bus.data_in = 8'hA5; bus.rxf_n = 1'b0;
    @(negedge clk); chk("t1_oe_idle", bus.oe_n, 1);
    @(negedge clk); chk("t1_oe_low", bus.oe_n, 0); chk("t1_rd_wait", bus.rd_n, 1);
    @(negedge clk); chk("t1_rd_low", bus.rd_n, 0);
    @(posedge clk); #1;
    send(8'h11); send(8'h22); send(8'h33); bus.rxf_n = 1'b1;
    @(negedge clk);
    chk("t1_we", bus.fb_we, 1); chk("t1_waddr", bus.fb_waddr, 0); chk("t1_wdata", bus.fb_wdata, 20'h32211);
    @(posedge clk); #1;
    gap(3);
    send_pix(20'hABCDE, 4'hF); send_pix(20'h00001, 4'hF); send_pix(20'hFFFFF, 4'h0); bus.rxf_n = 1'b1;
    @(negedge clk);
    chk("t1_last_we", bus.fb_we, 1); chk("t1_last_addr", bus.fb_waddr, 3);
    chk("t1_last_data", bus.fb_wdata, 20'hFFFFF); chk("t1_done", bus.frame_done, 1);
    @(posedge clk); #1;
    gap(2); pulse_fs();
    @(negedge clk); chk("t1_swap", bus.fb_sel, 1);
    // junk before sync, a mid-pixel stall, frame_start coincident with frame_done
    @(posedge clk); #1;
    send(8'h00); send(8'h7F); send(8'hA5);
    send_pix(20'h12345, 4'h0); send_pix(20'h6789A, 4'h0);
    send(8'hC3); send(8'hB2);
    bus.rxf_n = 1'b1;
    @(negedge clk); chk("t2_stall_rd", bus.rd_n, 1); chk("t2_stall_oe", bus.oe_n, 0);
    @(posedge clk); #1;
    gap(4);
    send(8'hE1); bus.rxf_n = 1'b1;
    @(negedge clk); chk("t2_p2_addr", bus.fb_waddr, 2); chk("t2_p2_data", bus.fb_wdata, 20'h1B2C3);
    @(posedge clk); #1;
    send_pix(20'h55555, 4'h0);
    bus.rxf_n = 1'b1; bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    @(negedge clk); chk("t2_no_swap", bus.fb_sel, 1);
    @(posedge clk); #1;
    gap(2); pulse_fs();
    @(negedge clk); chk("t2_swap", bus.fb_sel, 0);
    // mid-frame timeout, then a clean frame restarting at address 0
    @(posedge clk); #1;
    send(8'hA5); send_pix(20'h0F0F0, 4'h0); send(8'h77);
    bus.rxf_n = 1'b1;
    errs = 0; dones = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      errs += int'(bus.sync_err);
      dones += int'(bus.frame_done);
    end
    chk("to_err_pulses", errs, 1); chk("to_no_done", dones, 0);
    @(posedge clk); #1;
    send(8'hA5); send_pix(20'h24680, 4'h0); bus.rxf_n = 1'b1;
    @(negedge clk); chk("to_restart_addr", bus.fb_waddr, 0); chk("to_restart_data", bus.fb_wdata, 20'h24680);
    @(posedge clk); #1;
    send_pix(20'h11111, 4'h0); send_pix(20'h22222, 4'h0); send_pix(20'h33333, 4'h0);
    gap(2); pulse_fs();
    @(negedge clk); chk("to_swap", bus.fb_sel, 1);
    // reset mid-frame drops the partial frame and the displayed-buffer select
    @(posedge clk); #1;
    send(8'hA5); send(8'h99); send(8'h88); bus.rxf_n = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mr_oe_n", bus.oe_n, 1); chk("mr_sel", bus.fb_sel, 0); chk("mr_we", bus.fb_we, 0);
    chk("mr_waddr", bus.fb_waddr, 0); chk("mr_wdata", bus.fb_wdata, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'hA5); send_pix(20'hCAFE1, 4'h0); bus.rxf_n = 1'b1;
    @(negedge clk); chk("mr_after_addr", bus.fb_waddr, 0); chk("mr_after_data", bus.fb_wdata, 20'hCAFE1);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
